// File: rtl/min_max_leds.sv
// min_max_leds: registered LED bar showing val_i in a [min_i, max_i] window
// Ports: clk_i, rst_ni (sync, low), com_i mode, min_i/max_i/val_i, osc_i, leds_o
module min_max_leds #(
  parameter int VALSIZE = 4,
  parameter int ERRNO   = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [1:0]            com_i,
  input  logic [VALSIZE-1:0]    max_i,
  input  logic [VALSIZE-1:0]    min_i,
  input  logic                  osc_i,
  input  logic [VALSIZE-1:0]    val_i,
  output logic [2**VALSIZE-1:0] leds_o
);

  localparam int N = 2**VALSIZE;

  logic [N-1:0]       nxt;
  logic [VALSIZE-1:0] k;
  logic               in_win;
  logic               over;

  assign in_win = (min_i <= val_i) && (val_i <= max_i);
  assign over   = (val_i > max_i) && (min_i <= max_i);

  always_comb begin
    nxt = '0;
    k   = '0;
    unique case (com_i)
      2'b00: begin
        for (int i = 0; i < N; i++) begin
          k = i[VALSIZE-1:0];
          if (in_win) begin
            if (k >= min_i && k <= val_i)
              nxt[i] = 1'b1;
            else if (k > val_i && k <= max_i)
              nxt[i] = osc_i;
            if (ERRNO == 1 && k == val_i)
              nxt[i] = 1'b0;
          end else if (ERRNO == 3 && over) begin
            if (k >= min_i && k <= max_i)
              nxt[i] = 1'b1;
          end
        end
      end
      2'b01: begin
        for (int i = 0; i < N; i++) begin
          k = i[VALSIZE-1:0];
          nxt[i] = (k <= val_i);
        end
        if (ERRNO == 4)
          nxt[0] = 1'b0;
      end
      2'b10: nxt = '0;
      2'b11: begin
        nxt = '1;
        if (ERRNO == 2)
          nxt[N-1] = 1'b0;
      end
      default: nxt = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni)
      leds_o <= '0;
    else
      leds_o <= nxt;
  end

endmodule

// File: tb/tb_min_max_leds.sv
// tb_min_max_leds: directed literals plus randomized run vs behavioural model
// Ports exercised: all min_max_leds ports at VALSIZE = 4
module tb_min_max_leds;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  com;
  logic [3:0]  mx, mn, val;
  logic        osc;
  logic [15:0] leds;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q;
  bit          exp_ok = 1'b0;

  min_max_leds #(.VALSIZE(4), .ERRNO(0)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .com_i (com),
    .max_i (mx),
    .min_i (mn),
    .osc_i (osc),
    .val_i (val),
    .leds_o(leds)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model(
    input logic [1:0] c, input int lo, input int hi,
    input int v, input logic o);
    int r;
    int lit;
    int up;
    r = 0;
    case (c)
      2'b00: if (lo <= v && v <= hi) begin
        lit = ((1 << (v + 1)) - 1) - ((1 << lo) - 1);
        up  = ((1 << (hi + 1)) - 1) - ((1 << (v + 1)) - 1);
        r   = lit | (o ? up : 0);
      end
      2'b01: r = (1 << (v + 1)) - 1;
      2'b10: r = 0;
      default: r = 'hFFFF;
    endcase
    return r[15:0];
  endfunction

  task automatic check(input string name,
                       input logic [15:0] act,
                       input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n)
      exp_q <= 16'h0;
    else
      exp_q <= model(com, int'(mn), int'(mx), int'(val), osc);
    exp_ok <= 1'b1;
  end

  always @(negedge clk)
    if (exp_ok)
      check("model", leds, exp_q);

  task automatic apply(input string name, input logic r,
                       input logic [1:0] c, input logic [3:0] lo,
                       input logic [3:0] hi, input logic [3:0] v,
                       input logic o, input logic [15:0] req);
    @(negedge clk);
    rst_n = r; com = c; mn = lo; mx = hi; val = v; osc = o;
    @(posedge clk);
    #1;
    check(name, leds, req);
  endtask

  initial begin
    rst_n = 1'b0; com = 2'b11; mn = 4'd3;
    mx = 4'd9; val = 4'd5; osc = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset", leds, 16'h0000);

    apply("win_osc1", 1, 2'b00, 3, 12, 8, 1, 16'h1FF8);
    apply("win_osc0", 1, 2'b00, 3, 12, 8, 0, 16'h01F8);
    for (int i = 0; i < 4; i++)
      apply("win_tog", 1, 2'b00, 3, 12, 8, i[0],
            i[0] ? 16'h1FF8 : 16'h01F8);
    apply("win_full", 1, 2'b00, 0, 15, 15, 0, 16'hFFFF);
    apply("win_over", 1, 2'b00, 0, 14, 15, 1, 16'h0000);
    apply("win_under", 1, 2'b00, 5, 9, 4, 1, 16'h0000);
    apply("win_one", 1, 2'b00, 7, 7, 7, 1, 16'h0080);
    apply("win_inv", 1, 2'b00, 10, 2, 5, 1, 16'h0000);
    apply("lin_5", 1, 2'b01, 12, 1, 5, 0, 16'h003F);
    apply("lin_0", 1, 2'b01, 4, 9, 0, 1, 16'h0001);
    apply("lin_15", 1, 2'b01, 0, 0, 15, 0, 16'hFFFF);
    apply("off", 1, 2'b10, 3, 12, 8, 1, 16'h0000);
    apply("on", 1, 2'b11, 3, 12, 8, 0, 16'hFFFF);
    apply("sw_off", 1, 2'b10, 3, 12, 8, 1, 16'h0000);
    apply("sw_on", 1, 2'b11, 3, 12, 8, 1, 16'hFFFF);
    apply("sw_win", 1, 2'b00, 3, 12, 8, 1, 16'h1FF8);
    apply("mid_rst", 0, 2'b11, 3, 12, 8, 1, 16'h0000);
    apply("resume", 1, 2'b11, 3, 12, 8, 1, 16'hFFFF);

    for (int n = 0; n < 10000; n++) begin
      int lo, hi;
      @(negedge clk);
      lo    = $urandom_range(0, 14);
      hi    = $urandom_range(lo + 1, 15);
      rst_n = ($urandom_range(0, 199) != 0);
      mn    = lo[3:0];
      mx    = hi[3:0];
      if ($urandom_range(0, 9) == 0)
        val = 4'($urandom_range(0, 15));
      else
        val = 4'($urandom_range(lo, hi));
      osc   = 1'($urandom);
      com   = 2'($urandom);
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
